// File: rtl/seq_decoder_pkg.sv
// Shared types for the sequenced one-hot decoder: command encoding and FSM states.
package seq_decoder_pkg;

  // Command encoding carried on in_mode
  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_CLEAR     = 2'b11
  } mode_e;

  // Controller states: IDLE accepts commands, SCAN walks the code sequence
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/seq_decoder_onehot_dec.sv
// Combinational binary-to-one-hot decoder, shared by DIRECT and SCAN paths.
module onehot_dec #(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 32'd1 << SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] onehot
);

  // Exactly one bit set, chosen by sel; the output can never be multi-hot
  always_comb begin
    onehot      = {OUT_W{1'b0}};
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/seq_decoder.sv
// Sequenced one-hot decoder: decodes a single select code (DIRECT) or walks
// a run of in_len+1 consecutive codes up or down (SCAN), with abort and
// clear. All outputs are registered; in_ready is the only combinational one.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter  int SEL_W      = 3,
  parameter  int LEN_W      = 4,
  parameter  int ACTIVE_LOW = 0,
  localparam int OUT_W      = 32'd1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [LEN_W-1:0] in_len,
  input  logic             abort,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             busy,
  output logic             done
);

  // Inactive level of y depends on output polarity
  localparam logic [OUT_W-1:0] Y_INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1'b1);
  localparam logic [LEN_W-1:0] LEN_ZERO   = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1'b1);

  state_e           state_r;
  logic [SEL_W-1:0] code_r;     // code currently shown on y
  logic [LEN_W-1:0] remain_r;   // codes still to emit after the current one
  logic             dir_up_r;   // scan direction latched at acceptance

  logic             accept_s;
  logic [SEL_W-1:0] step_code_s;
  logic [SEL_W-1:0] dec_code_s;
  logic [OUT_W-1:0] dec_s;
  logic [OUT_W-1:0] y_next_s;

  // Commands are accepted only in IDLE, never during abort or reset
  assign in_ready = rst_n & (state_r == ST_IDLE) & ~abort;
  assign accept_s = in_valid & in_ready;

  // Next scan code; wraps modulo OUT_W through natural SEL_W-bit overflow
  always_comb begin
    step_code_s = code_r;
    if (dir_up_r) begin
      step_code_s = code_r + SEL_ONE;
    end else begin
      step_code_s = code_r - SEL_ONE;
    end
  end

  // A new command decodes its own select; otherwise the scan steps onward
  always_comb begin
    dec_code_s = step_code_s;
    if (accept_s) begin
      dec_code_s = in_sel;
    end else begin
      dec_code_s = step_code_s;
    end
  end

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (dec_code_s),
    .onehot (dec_s)
  );

  // Polarity applied in exactly one place, right before the y register
  always_comb begin
    y_next_s = dec_s;
    if (ACTIVE_LOW != 0) begin
      y_next_s = ~dec_s;
    end else begin
      y_next_s = dec_s;
    end
  end

  // Controller FSM with registered y, y_valid, busy and done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      y        <= Y_INACTIVE;
      y_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      code_r   <= {SEL_W{1'b0}};
      remain_r <= LEN_ZERO;
      dir_up_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (abort) begin
            // Abort in IDLE clears the held code; in_ready is low so nothing is accepted
            y       <= Y_INACTIVE;
            y_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (accept_s) begin
            case (mode_e'(in_mode))
              MODE_DIRECT: begin
                y       <= y_next_s;
                y_valid <= 1'b1;
                busy    <= 1'b0;
                code_r  <= in_sel;
              end
              MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                // First code appears immediately; a zero length is also the last code
                state_r  <= ST_SCAN;
                y        <= y_next_s;
                y_valid  <= 1'b1;
                busy     <= 1'b1;
                code_r   <= in_sel;
                remain_r <= in_len;
                dir_up_r <= (in_mode == MODE_SCAN_UP);
                done     <= (in_len == LEN_ZERO);
              end
              MODE_CLEAR: begin
                y       <= Y_INACTIVE;
                y_valid <= 1'b0;
                busy    <= 1'b0;
              end
              default: begin
                y       <= Y_INACTIVE;
                y_valid <= 1'b0;
                busy    <= 1'b0;
              end
            endcase
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (abort) begin
            // Abort wins over the last code, so done never pulses here
            state_r  <= ST_IDLE;
            y        <= Y_INACTIVE;
            y_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            remain_r <= LEN_ZERO;
          end else if (remain_r == LEN_ZERO) begin
            // Last code was shown last cycle; hold it on y and return to IDLE
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else begin
            code_r   <= step_code_s;
            remain_r <= remain_r - LEN_ONE;
            y        <= y_next_s;
            y_valid  <= 1'b1;
            busy     <= 1'b1;
            done     <= (remain_r == LEN_ONE);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          y        <= Y_INACTIVE;
          y_valid  <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          remain_r <= LEN_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder: each driven cycle pushes the hand-computed
// outputs expected in that cycle; a negedge monitor pops and compares.
module tb_seq_decoder;
  import seq_decoder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: defaults (SEL_W=3, active-high)
  logic       rst_n0 = 1'b0, in_valid0 = 1'b0, abort0 = 1'b0;
  logic [1:0] in_mode0 = 2'b00;
  logic [2:0] in_sel0 = 3'd0;
  logic [3:0] in_len0 = 4'd0;
  logic       in_ready0, y_valid0, busy0, done0;
  logic [7:0] y0;

  // Instance 1: SEL_W=2, active-low
  logic       rst_n1 = 1'b0, in_valid1 = 1'b0, abort1 = 1'b0;
  logic [1:0] in_mode1 = 2'b00;
  logic [1:0] in_sel1 = 2'd0;
  logic [3:0] in_len1 = 4'd0;
  logic       in_ready1, y_valid1, busy1, done1;
  logic [3:0] y1;

  seq_decoder u_dut0 (
    .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_mode(in_mode0), .in_sel(in_sel0), .in_len(in_len0), .abort(abort0),
    .y(y0), .y_valid(y_valid0), .busy(busy0), .done(done0)
  );

  seq_decoder #(.SEL_W(2), .LEN_W(4), .ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_mode(in_mode1), .in_sel(in_sel1), .in_len(in_len1), .abort(abort1),
    .y(y1), .y_valid(y_valid1), .busy(busy1), .done(done1)
  );

  typedef struct {
    int       cyc;
    bit       inst;
    logic [7:0] y;
    logic     yv;
    logic     busy;
    logic     done;
    logic     rdy;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Drive one cycle of instance 0 and record what it must show this cycle
  task automatic v0(input logic rstn, input logic valid, input logic [1:0] mode,
                    input logic [2:0] sel, input logic [3:0] len, input logic abrt,
                    input logic [7:0] ey, input logic eyv, input logic eb,
                    input logic ed, input logic er);
    exp_t e;
    @(posedge clk); #2;
    rst_n0 = rstn; in_valid0 = valid; in_mode0 = mode;
    in_sel0 = sel; in_len0 = len; abort0 = abrt;
    e.cyc = cyc; e.inst = 1'b0; e.y = ey; e.yv = eyv;
    e.busy = eb; e.done = ed; e.rdy = er;
    q.push_back(e);
  endtask

  // Drive one cycle of instance 1 and record what it must show this cycle
  task automatic v1(input logic rstn, input logic valid, input logic [1:0] mode,
                    input logic [1:0] sel, input logic [3:0] len, input logic abrt,
                    input logic [3:0] ey, input logic eyv, input logic eb,
                    input logic ed, input logic er);
    exp_t e;
    @(posedge clk); #2;
    rst_n1 = rstn; in_valid1 = valid; in_mode1 = mode;
    in_sel1 = sel; in_len1 = len; abort1 = abrt;
    e.cyc = cyc; e.inst = 1'b1; e.y = {4'h0, ey}; e.yv = eyv;
    e.busy = eb; e.done = ed; e.rdy = er;
    q.push_back(e);
  endtask

  // Monitor: pops expectations due this cycle and checks the y invariant
  exp_t m;
  logic [7:0] act_y;
  logic act_yv, act_b, act_d, act_r;
  always @(negedge clk) begin
    if (cyc > 0) begin
      n_checks++;
      if (!(y0 == 8'h00 || $onehot(y0))) begin
        n_errors++;
        $display("FAIL onehot0 cyc=%0d y=%b", cyc, y0);
      end
      n_checks++;
      if (!(y1 == 4'hF || $onehot(~y1))) begin
        n_errors++;
        $display("FAIL onecold1 cyc=%0d y=%b", cyc, y1);
      end
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      if (m.inst) begin
        act_y = {4'h0, y1}; act_yv = y_valid1; act_b = busy1; act_d = done1; act_r = in_ready1;
      end else begin
        act_y = y0; act_yv = y_valid0; act_b = busy0; act_d = done0; act_r = in_ready0;
      end
      n_checks++;
      if (m.cyc != cyc || act_y !== m.y || act_yv !== m.yv || act_b !== m.busy ||
          act_d !== m.done || act_r !== m.rdy) begin
        n_errors++;
        $display("FAIL dut%0d cyc=%0d (due %0d) got y=%h yv=%b busy=%b done=%b rdy=%b want y=%h yv=%b busy=%b done=%b rdy=%b",
                 m.inst, cyc, m.cyc, act_y, act_yv, act_b, act_d, act_r,
                 m.y, m.yv, m.busy, m.done, m.rdy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] ey;

  initial begin
    // Reset, in_ready low while rst_n=0
    v0(1'b0, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    v0(1'b0, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // DIRECT sel=5, held for 10 idle cycles
    v0(1'b1, 1'b1, MODE_DIRECT, 3'd5, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    // SCAN_UP sel=6 len=3; a competing DIRECT is held on in_valid throughout
    v0(1'b1, 1'b1, MODE_SCAN_UP, 3'd6, 4'd3, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b1, MODE_DIRECT, 3'd2, 4'd0, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b1, MODE_DIRECT, 3'd2, 4'd0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b1, MODE_DIRECT, 3'd2, 4'd0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b1, MODE_DIRECT, 3'd2, 4'd0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0);
    // Back-to-back: SCAN_DOWN sel=1 len=0 in the idle-accept cycle
    v0(1'b1, 1'b1, MODE_SCAN_DOWN, 3'd1, 4'd0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    // SCAN_DOWN sel=1 len=2 wraps 1,0,7
    v0(1'b1, 1'b1, MODE_SCAN_DOWN, 3'd1, 4'd2, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    // CLEAR
    v0(1'b1, 1'b1, MODE_CLEAR, 3'd0, 4'd0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // SCAN_UP sel=0 len=15, abort on the 5th code
    v0(1'b1, 1'b1, MODE_SCAN_UP, 3'd0, 4'd15, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Abort in IDLE blocks a concurrent command and clears y
    v0(1'b1, 1'b1, MODE_DIRECT, 3'd3, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b1, MODE_DIRECT, 3'd7, 4'd0, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Long scan, len=9 >= 8 wraps: 6,7,0,...,7
    v0(1'b1, 1'b1, MODE_SCAN_UP, 3'd6, 4'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      ey = 8'h01 << ((6 + i) % 8);
      v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, ey, 1'b1, 1'b1, (i == 9), 1'b0);
    end
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    // Reset mid-scan with concurrent abort and in_valid
    v0(1'b1, 1'b1, MODE_SCAN_UP, 3'd2, 4'd5, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b0, 1'b1, MODE_DIRECT, 3'd5, 4'd0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      v0(1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Active-low instance, SEL_W=2
    v1(1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    v1(1'b1, 1'b1, MODE_DIRECT, 2'd2, 4'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    v1(1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1);
    v1(1'b1, 1'b1, MODE_CLEAR, 2'd0, 4'd0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1);
    v1(1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    v1(1'b1, 1'b1, MODE_SCAN_DOWN, 2'd0, 4'd1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    v1(1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0);
    v1(1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0);
    v1(1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 The block SHALL take parameter SEL_W, default 3, the select width; OUT_W = 2**SEL_W is derived and SHALL NOT be overridable.
REQ-002 The block SHALL take parameter LEN_W, default 4, the scan-length field width.
REQ-003 The block SHALL take parameter ACTIVE_LOW, default 0; when 1, the y output is the bitwise inverse of the one-hot code.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; ports are as follows.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 in_valid  in  1  command valid.
REQ-008 in_ready  out  1  command accept; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-009 in_mode  in  2  command: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 CLEAR.
REQ-010 in_sel  in  SEL_W  select code, or scan start code.
REQ-011 in_len  in  LEN_W  scan emits in_len+1 codes.
REQ-012 abort  in  1  terminate the scan and clear outputs.
REQ-013 y  out  OUT_W  registered one-hot (or one-cold) decode.
REQ-014 y_valid  out  1  y holds a decoded code.
REQ-015 busy  out  1  scan in progress.
REQ-016 done  out  1  one-cycle pulse on the last scan code.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-018 in_ready SHALL equal (state==IDLE) AND NOT abort, combinationally.
REQ-019 DIRECT accepted: the next cycle, y = onehot(in_sel) and y_valid=1; the value holds until the next accepted command or abort; the state remains IDLE.
REQ-020 CLEAR accepted: the next cycle, y = inactive (all zero; all ones if ACTIVE_LOW) and y_valid=0.
REQ-021 SCAN_UP/SCAN_DOWN accepted: state goes to SCAN, busy=1, and y = onehot(in_sel) the next cycle.
REQ-022 Each following SCAN cycle, the code SHALL step +1 (UP) or -1 (DOWN) modulo OUT_W, wrapping 7->0 and 0->7 at SEL_W=3.
REQ-023 Exactly in_len+1 codes SHALL be emitted, one per cycle, with no gaps.
REQ-024 in_len=0 SHALL emit one code, with done and busy behaving as for the last code.
REQ-025 done=1 SHALL coincide with the cycle in which the last code is on y.
REQ-026 The next cycle after the last code, the state SHALL be IDLE, busy=0, and y SHALL hold the last code with y_valid=1.
REQ-027 in_len >= OUT_W SHALL be legal; the scan wraps repeatedly.
REQ-028 Back-to-back commands: a command accepted in the cycle after done SHALL take effect normally, giving one idle-accept cycle between scans.
REQ-029 abort in SCAN: the next cycle, state=IDLE, y inactive, y_valid=0, busy=0, and done SHALL NOT pulse.
REQ-030 abort in IDLE: y and y_valid SHALL clear the next cycle, and any concurrent in_valid SHALL NOT be accepted.
REQ-031 in_sel, in_mode and in_len SHALL be sampled only on acceptance; changes during SCAN are ignored.
REQ-032 y SHALL always be one-hot or inactive; no multi-hot value is permitted at any time.

Reset
REQ-033 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, y inactive, y_valid=0, busy=0, done=0, and clear the internal counters.
REQ-034 Reset mid-scan SHALL take precedence over abort and commands, and no done SHALL follow.
REQ-035 in_ready SHALL be 0 while rst_n=0.

Structure
REQ-036 The shared package seq_decoder_pkg SHALL hold the mode encoding enum and the FSM state enum.
REQ-037 One combinational sub-module, onehot_dec (SEL_W -> OUT_W), SHALL perform the decode and is reused for both DIRECT and SCAN.
REQ-038 The polarity inversion for ACTIVE_LOW SHALL be applied once, at the output register.

Verification
REQ-039 Reset, then DIRECT sel=5 -> next cycle y=8'b0010_0000, y_valid=1, and the value holds for 10 idle cycles.
REQ-040 SCAN_UP sel=6 len=3 -> y = bit6, bit7, bit0, bit1 on consecutive cycles; done with bit1; busy=1 for 4 cycles; in_ready=0 throughout.
REQ-041 SCAN_DOWN sel=1 len=0 -> a single cycle of bit1 with done=1, then IDLE holding bit1.
REQ-042 SCAN_UP sel=0 len=15, abort asserted on the 5th code -> next cycle y=0, y_valid=0, no done pulse.
REQ-043 rst_n=0 mid-scan with concurrent abort and in_valid -> all outputs at reset values the next cycle, no done pulse, and in_ready=0 during reset.
REQ-044 ACTIVE_LOW=1, SEL_W=2: reset -> y=4'b1111; DIRECT sel=2 -> y=4'b1011; CLEAR -> y=4'b1111, y_valid=0.
